// File: rtl/ram256_arb_pkg.sv
// Shared types and constants for the two-port arbiter in front of the 256x8 RAM.
package ram256_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_LAST = 2'd1,
    B_LAST = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } ram_req_t;

  localparam int RUN_CNT_W = 4;

  // Encoding of the round-robin pointer: which port was granted most recently.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram256_arb_rr_pick2.sv
// Combinational two-way winner selection: single requester wins, otherwise lock
// keeps the owner unless starved, else the port that was not served last wins.
module rr_pick2
  import ram256_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock_hold,
  input  logic       starved,
  output logic [1:0] gnt
);

  logic keep_owner;
  logic winner;

  always_comb begin
    gnt        = 2'b00;
    keep_owner = lock_hold && !starved;
    winner     = keep_owner ? last : ~last;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (winner == PORT_B) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram256_arb.sv
// Arbiter/sequencer sharing one single-port 256x8 RAM between port A and port B,
// with round-robin, bounded lock bursts and a registered one-cycle read return.
module ram256_arb
  import ram256_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  input  logic       a_lock,
  output logic       a_gnt,
  output logic       a_rvalid,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_wdata,
  input  logic       b_lock,
  output logic       b_gnt,
  output logic       b_rvalid,
  output logic [7:0] b_rdata,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);

  localparam logic [RUN_CNT_W-1:0] STARVE_LIM = RUN_CNT_W'(STARVE_MAX);
  localparam logic [RUN_CNT_W-1:0] RUN_ONE    = RUN_CNT_W'(1);

  arb_state_t           state, state_nxt;
  logic                 last, last_nxt;
  logic                 lock_q, lock_nxt;
  logic [RUN_CNT_W-1:0] run_cnt, run_nxt;
  logic [1:0]           req, gnt;
  logic                 owner_req, lock_hold, starved;
  ram_req_t             ram_sel;
  logic                 vld_a_p1, vld_b_p1;
  logic [7:0]           rdata_a_p1, rdata_b_p1;

  function automatic logic [RUN_CNT_W-1:0] sat_inc(input logic [RUN_CNT_W-1:0] v);
    return (v == {RUN_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign req       = {b_req, a_req};
  assign owner_req = (last == PORT_B) ? b_req : a_req;
  assign lock_hold = (state != IDLE) && lock_q && owner_req;
  assign starved   = (run_cnt >= STARVE_LIM);

  rr_pick2 u_pick (
    .req       (req),
    .last      (last),
    .lock_hold (lock_hold),
    .starved   (starved),
    .gnt       (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  always_comb begin
    state_nxt = IDLE;
    last_nxt  = last;
    lock_nxt  = 1'b0;
    run_nxt   = '0;
    case (gnt)
      2'b01: begin
        state_nxt = A_LAST;
        last_nxt  = PORT_A;
        lock_nxt  = a_lock;
        if (b_req) run_nxt = (state == A_LAST) ? sat_inc(run_cnt) : RUN_ONE;
      end
      2'b10: begin
        state_nxt = B_LAST;
        last_nxt  = PORT_B;
        lock_nxt  = b_lock;
        if (a_req) run_nxt = (state == B_LAST) ? sat_inc(run_cnt) : RUN_ONE;
      end
      default: ;
    endcase
  end

  always_comb begin
    ram_sel = '0;
    if (gnt[0])      ram_sel = '{we: a_we, addr: a_addr, wdata: a_wdata};
    else if (gnt[1]) ram_sel = '{we: b_we, addr: b_addr, wdata: b_wdata};
  end

  assign ram_we   = ram_sel.we;
  assign ram_addr = ram_sel.addr;
  assign ram_din  = ram_sel.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= PORT_B;
      lock_q  <= 1'b0;
      run_cnt <= '0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      lock_q  <= lock_nxt;
      run_cnt <= run_nxt;
    end
  end

  // p1: read data captured at the grant edge, returned the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a_p1   <= 1'b0;
      vld_b_p1   <= 1'b0;
      rdata_a_p1 <= '0;
      rdata_b_p1 <= '0;
    end else begin
      vld_a_p1 <= gnt[0] && !a_we;
      vld_b_p1 <= gnt[1] && !b_we;
      if (gnt[0] && !a_we) rdata_a_p1 <= ram_dout;
      if (gnt[1] && !b_we) rdata_b_p1 <= ram_dout;
    end
  end

  assign a_rvalid = vld_a_p1;
  assign a_rdata  = rdata_a_p1;
  assign b_rvalid = vld_b_p1;
  assign b_rdata  = rdata_b_p1;

endmodule

// File: tb/tb_ram256_arb.sv
// Bench for ram256_arb: vector table, hand-written corner sequences and random
// traffic against a transaction-level reference model with its own memory image.
module tb_ram256_arb;
  import ram256_arb_pkg::*;

  localparam int STARVE_MAX = 4;

  typedef struct packed {
    logic       req;
    logic       we;
    logic       lock;
    logic [7:0] addr;
    logic [7:0] wdata;
  } port_t;

  typedef struct packed {
    logic       rst;
    port_t      a;
    port_t      b;
    logic       e_ag;
    logic       e_bg;
    logic       e_arv;
    logic [7:0] e_ard;
    logic       e_brv;
    logic [7:0] e_brd;
  } vec_t;

  localparam port_t NOP = '0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
  logic       b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [7:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we;
  logic [7:0] a_rdata, b_rdata, ram_addr, ram_din, ram_dout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram256_arb #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // External RAM: synchronous write, asynchronous read.
  logic [7:0] ram [256];
  assign ram_dout = ram[ram_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_din;

  // Requesters must hold their request until it is granted.
  port_t a_prev, b_prev;
  logic  a_wait = 1'b0, b_wait = 1'b0;
  always @(posedge clk) begin
    if (rst_n && a_wait)
      assert ({a_req, a_we, a_lock, a_addr, a_wdata} == a_prev) else $error("requester rule broken on port A");
    if (rst_n && b_wait)
      assert ({b_req, b_we, b_lock, b_addr, b_wdata} == b_prev) else $error("requester rule broken on port B");
    a_wait <= rst_n && a_req && !a_gnt;
    b_wait <= rst_n && b_req && !b_gnt;
    a_prev <= {a_req, a_we, a_lock, a_addr, a_wdata};
    b_prev <= {b_req, b_we, b_lock, b_addr, b_wdata};
  end

  // Reference model: who was served last, whether that grant carried a lock,
  // how long the current contended run is, and the pending read returns.
  logic [7:0] mem [256];
  int         m_last, m_prev, m_run;
  logic       m_prev_lock;
  logic       m_rv [2];
  logic [7:0] m_rd [2];

  task automatic model_reset();
    m_last = 1; m_prev = -1; m_prev_lock = 1'b0; m_run = 0;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
  endtask

  function automatic int model_winner(input port_t pa, input port_t pb);
    if (pa.req && !pb.req) return 0;
    if (pb.req && !pa.req) return 1;
    if (!pa.req && !pb.req) return -1;
    if (m_prev >= 0 && m_prev_lock) return (m_run < STARVE_MAX) ? m_prev : 1 - m_prev;
    return 1 - m_last;
  endfunction

  task automatic model_commit(input port_t pa, input port_t pb, input int w);
    port_t p [2];
    logic  other;
    p[0] = pa; p[1] = pb;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0;
    if (w < 0) begin
      m_prev = -1; m_prev_lock = 1'b0; m_run = 0;
    end else begin
      other = p[1-w].req;
      if (p[w].we) mem[p[w].addr] = p[w].wdata;
      else begin m_rv[w] = 1'b1; m_rd[w] = mem[p[w].addr]; end
      if (!other)           m_run = 0;
      else if (w == m_prev) m_run = (m_run < 15) ? m_run + 1 : 15;
      else                  m_run = 1;
      m_prev = w; m_prev_lock = p[w].lock; m_last = w;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_ag, input logic e_bg,
                          input logic e_rwe, input logic [7:0] e_raddr, input logic [7:0] e_rdin,
                          input logic e_arv, input logic [7:0] e_ard,
                          input logic e_brv, input logic [7:0] e_brd);
    chk({tag, ".a_gnt"},    16'(a_gnt),    16'(e_ag));
    chk({tag, ".b_gnt"},    16'(b_gnt),    16'(e_bg));
    chk({tag, ".ram_we"},   16'(ram_we),   16'(e_rwe));
    chk({tag, ".ram_addr"}, 16'(ram_addr), 16'(e_raddr));
    chk({tag, ".ram_din"},  16'(ram_din),  16'(e_rdin));
    chk({tag, ".a_rvalid"}, 16'(a_rvalid), 16'(e_arv));
    chk({tag, ".a_rdata"},  16'(a_rdata),  16'(e_ard));
    chk({tag, ".b_rvalid"}, 16'(b_rvalid), 16'(e_brv));
    chk({tag, ".b_rdata"},  16'(b_rdata),  16'(e_brd));
  endtask

  function automatic port_t mkp(input int req, input int we, input int lock, input int addr, input int wdata);
    port_t p;
    p.req = 1'(req); p.we = 1'(we); p.lock = 1'(lock); p.addr = 8'(addr); p.wdata = 8'(wdata);
    return p;
  endfunction

  function automatic vec_t mkv(input int rst, input port_t pa, input port_t pb, input int ag, input int bg,
                               input int arv, input int ard, input int brv, input int brd);
    vec_t v;
    v.rst = 1'(rst); v.a = pa; v.b = pb; v.e_ag = 1'(ag); v.e_bg = 1'(bg);
    v.e_arv = 1'(arv); v.e_ard = 8'(ard); v.e_brv = 1'(brv); v.e_brd = 8'(brd);
    return v;
  endfunction

  task automatic drive(input port_t pa, input port_t pb);
    @(negedge clk);
    a_req = pa.req; a_we = pa.we; a_lock = pa.lock; a_addr = pa.addr; a_wdata = pa.wdata;
    b_req = pb.req; b_we = pb.we; b_lock = pb.lock; b_addr = pb.addr; b_wdata = pb.wdata;
    #1;
  endtask

  task automatic step(input port_t pa, input port_t pb, input string tag, output int w);
    port_t g;
    drive(pa, pb);
    w = model_winner(pa, pb);
    g = (w == 0) ? pa : (w == 1) ? pb : NOP;
    chk_outs(tag, w == 0, w == 1, g.we, g.addr, g.wdata, m_rv[0], m_rd[0], m_rv[1], m_rd[1]);
    model_commit(pa, pb, w);
  endtask

  task automatic zero_inputs();
    a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic reset_dut();
    zero_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [12];

  initial begin
    int    w, k, j;
    logic [11:0] gpat;
    port_t pa, pb;
    logic  a_pend, b_pend;

    for (int i = 0; i < 256; i++) begin
      ram[i] <= 8'(i) ^ 8'hA5;
      mem[i]  = 8'(i) ^ 8'hA5;
    end

    // Table: A write/read, tie alternation from reset, A write then B read.
    tbl[0]  = mkv(1, mkp(1,1,0,8'h10,8'h5A), NOP,                1,0, 0,8'h00, 0,8'h00);
    tbl[1]  = mkv(0, mkp(1,0,0,8'h10,0),     NOP,                1,0, 0,8'h00, 0,8'h00);
    tbl[2]  = mkv(0, NOP,                    NOP,                0,0, 1,8'h5A, 0,8'h00);
    tbl[3]  = mkv(0, NOP,                    NOP,                0,0, 0,8'h5A, 0,8'h00);
    tbl[4]  = mkv(1, mkp(1,0,0,8'h10,0),     mkp(1,0,0,8'h11,0), 1,0, 0,8'h00, 0,8'h00);
    tbl[5]  = mkv(0, mkp(1,0,0,8'h10,0),     mkp(1,0,0,8'h11,0), 0,1, 1,8'h5A, 0,8'h00);
    tbl[6]  = mkv(0, mkp(1,0,0,8'h10,0),     mkp(1,0,0,8'h12,0), 1,0, 0,8'h5A, 1,8'hB4);
    tbl[7]  = mkv(0, mkp(1,1,0,8'h20,8'hC3), mkp(1,0,0,8'h12,0), 0,1, 1,8'h5A, 0,8'hB4);
    tbl[8]  = mkv(0, mkp(1,1,0,8'h20,8'hC3), NOP,                1,0, 0,8'h5A, 1,8'hB7);
    tbl[9]  = mkv(0, NOP,                    mkp(1,0,0,8'h20,0), 0,1, 0,8'h5A, 0,8'hB7);
    tbl[10] = mkv(0, NOP,                    NOP,                0,0, 0,8'h5A, 1,8'hC3);
    tbl[11] = mkv(0, NOP,                    NOP,                0,0, 0,8'h5A, 0,8'hC3);

    reset_dut();
    #1;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);

    for (int i = 0; i < 12; i++) begin
      port_t g;
      if (tbl[i].rst) reset_dut();
      drive(tbl[i].a, tbl[i].b);
      g = tbl[i].e_ag ? tbl[i].a : tbl[i].e_bg ? tbl[i].b : NOP;
      chk_outs($sformatf("vec%0d", i), tbl[i].e_ag, tbl[i].e_bg, g.we, g.addr, g.wdata,
               tbl[i].e_arv, tbl[i].e_ard, tbl[i].e_brv, tbl[i].e_brd);
      w = model_winner(tbl[i].a, tbl[i].b);
      model_commit(tbl[i].a, tbl[i].b, w);
    end

    // Locked burst of 10 A reads against a continuously requesting B.
    reset_dut();
    k = 0; j = 0; gpat = '0;
    for (int c = 0; c < 16 && k < 10; c++) begin
      step(mkp(1, 0, int'(k < 9), 8'h40 + k, 0), mkp(1, 0, 0, 8'h80 + j, 0), $sformatf("lock%0d", c), w);
      if (c < 12) gpat[c] = a_gnt;
      if (w == 0) k++;
      if (w == 1) j++;
    end
    chk("lock.grant_seq", 16'(gpat), 16'h0DEF);
    step(NOP, mkp(1, 0, 0, 8'h80 + j, 0), "lock.tail", w);
    step(NOP, NOP, "lock.flush", w);

    // Reset asserted between edges just after a read return was raised.
    reset_dut();
    step(mkp(1, 0, 0, 8'h10, 0), NOP, "mrst.read", w);
    @(posedge clk);
    #2;
    chk("mrst.rvalid_before", 16'(a_rvalid), 16'(m_rv[0]));
    chk("mrst.rdata_before",  16'(a_rdata),  16'(m_rd[0]));
    zero_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst.rvalid_in_reset", 16'(a_rvalid), 16'h0000);
    chk("mrst.rdata_in_reset",  16'(a_rdata),  16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(mkp(1, 0, 0, 8'h11, 0), mkp(1, 0, 0, 8'h12, 0), "mrst.tie", w);
    chk("mrst.tie_a_first", 16'(a_gnt), 16'h0001);
    step(NOP, mkp(1, 0, 0, 8'h12, 0), "mrst.b", w);
    step(NOP, NOP, "mrst.flush", w);

    // An idle cycle drops lock history; the next tie is plain round-robin.
    reset_dut();
    step(mkp(1, 1, 1, 8'h30, 8'h66), NOP, "idle.lockw", w);
    step(NOP, NOP, "idle.gap", w);
    step(mkp(1, 0, 0, 8'h30, 0), mkp(1, 0, 0, 8'h31, 0), "idle.tie", w);
    chk("idle.tie_b_gnt", 16'(b_gnt), 16'h0001);
    step(mkp(1, 0, 0, 8'h30, 0), NOP, "idle.a", w);
    step(NOP, NOP, "idle.flush", w);

    // Random traffic on a small address window to force hazards and contention.
    reset_dut();
    pa = NOP; pb = NOP; a_pend = 1'b0; b_pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!a_pend)
        pa = mkp(int'($urandom_range(0, 99) < 70), $urandom_range(0, 1), int'($urandom_range(0, 99) < 50),
                 $urandom_range(0, 15), $urandom_range(0, 255));
      if (!b_pend)
        pb = mkp(int'($urandom_range(0, 99) < 70), $urandom_range(0, 1), int'($urandom_range(0, 99) < 50),
                 $urandom_range(0, 15), $urandom_range(0, 255));
      step(pa, pb, $sformatf("rnd%0d", c), w);
      a_pend = pa.req && (w != 0);
      b_pend = pb.req && (w != 1);
    end
    step(NOP, NOP, "rnd.flush", w);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram256_arb.md
Name: ram256_arb

Overview:
- Two-port arbiter and sequencer in front of the single-port 256x8 RAM (sync write, async read).
- Shares the RAM between port A (CPU) and port B (DMA/loader), one transfer per cycle.
- Round-robin tie-break; optional lock for bursts, with a starvation bound.
- Read data is registered and returned per port one cycle after the grant.

Parameters:
- STARVE_MAX, 4: max consecutive locked grants to one port while the other port is requesting (legal range 1..15).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  port A requests a transfer this cycle
- a_we  in  1  port A: 1 = write, 0 = read
- a_addr  in  8  port A byte address
- a_wdata  in  8  port A write data
- a_lock  in  1  port A asks to keep the grant next cycle
- a_gnt  out  1  port A transfer accepted this cycle (combinational)
- a_rvalid  out  1  port A read data valid (one-cycle pulse)
- a_rdata  out  8  port A read data (registered)
- b_req, b_we, b_addr, b_wdata, b_lock, b_gnt, b_rvalid, b_rdata: same as port A, for port B
- ram_we  out  1  RAM write enable
- ram_addr  out  8  RAM address
- ram_din  out  8  RAM write data
- ram_dout  in  8  RAM read data (async, valid same cycle as ram_addr)

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low.
- Reset values: a/b_rvalid=0, a/b_rdata=8'h00, last=B, run_cnt=0, FSM=IDLE. Grants and RAM outputs are combinational, so they are 0 while no request is present.
- Transfer: happens on a rising edge where req&gnt=1. At most one gnt is high per cycle, and gnt is never high without req.
- RAM drive when granted: ram_addr=x_addr; ram_din=x_wdata; ram_we=x_we.
- RAM drive with no grant: ram_we=0, ram_addr=0, ram_din=0.
- Write: data is committed at the grant edge. No response is generated (rvalid stays 0).
- Read: ram_dout is sampled into x_rdata at the grant edge, and x_rvalid=1 for exactly the next cycle. Latency is 1.
- x_rdata holds its value until that port's next read.
- FSM states:
  - IDLE: no grant last cycle.
  - A_LAST: A was granted last cycle.
  - B_LAST: B was granted last cycle.
- Next state: follows the winner, or IDLE if no grant.
- Winner selection:
  - Only one port requests: that port wins.
  - Both request, no lock in effect: the port that is not `last` wins (alternation). `last` updates on every grant.
  - Lock in effect: the state is A_LAST or B_LAST, that owner asserted lock in its granted cycle, and the owner requests again. The owner wins if run_cnt < STARVE_MAX; otherwise the other port wins.
- run_cnt:
  - Increments on each grant to the same owner while the other port is requesting (saturates at 15).
  - Clears on owner change, on IDLE, or when the other port's req=0.
- Back-to-back write then read of the same address, any ports: the read returns the new data.
- Requester rule: req, we, addr, wdata and lock are held stable until gnt. The bench asserts this rule; the RTL does not check it.
- Reset mid-operation: any pending rvalid is dropped, and the FSM and pointer return to their reset values immediately (async).

Decomposition:
- Package ram256_arb_pkg:
  - typedef enum logic [1:0] {IDLE, A_LAST, B_LAST} arb_state_t
  - typedef struct {we, addr[7:0], wdata[7:0]} ram_req_t
  - localparam RUN_CNT_W = 4
- Sub-module rr_pick2 (combinational): inputs req[1:0], last, lock_hold, starved; output gnt[1:0].
- The top module holds the FSM, run_cnt, the per-port read-return registers and the RAM mux. The RAM itself is instantiated outside.

Test Plan:
- Reset, then A only: write 0x10<-0x5A, then read 0x10 → a_gnt=1 both cycles; a_rvalid pulses the cycle after the read; a_rdata=0x5A; b_* stay 0.
- Both request every cycle, no lock, from reset → grants go A,B,A,B; each port's rvalid follows one cycle after its own read gnt.
- A locked burst of 10 reads with B requesting, STARVE_MAX=4 → 4 grants to A, 1 to B, 4 to A, 1 to B, then A finishes; run_cnt never exceeds 4.
- A writes 0x20<-0xC3, next cycle B reads 0x20 → b_rdata=0xC3 with b_rvalid high on cycle 3.
- rst_n pulsed low mid-cycle while a_rvalid would rise → a_rvalid=0, a_rdata=0x00 immediately; the next tie grants A first.
- Idle cycles between requests → ram_we=0, ram_addr=0; FSM returns to IDLE; lock history is cleared, so the next tie uses round-robin.
